// File: rtl/tx_retry_control.sv
// rtl/tx_retry_control.sv - USB-PD TCPC transmit launch, GoodCRC wait and retry controller
// Drives one PHY frame per TRANSMIT write, retries on GoodCRC timeout and reports the outcome in ALERT[6:4].
`timescale 1ns/1ps
module tx_retry_control #(
  parameter int CRC_TIMEOUT = 16,
  parameter int ALERT_W     = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [7:0]         iTRANSMIT,
  input  logic               iTxReq,
  input  logic [ALERT_W-1:0] iAlert,
  output logic [ALERT_W-1:0] oAlert,
  input  logic               iRxMessage,
  output logic               oPHY_TxStart,
  output logic [2:0]         oPHY_TxType,
  input  logic               iPHY_TxDone,
  input  logic               iGoodCRC,
  output logic               oBusy,
  output logic [7:0]         oTRANSMIT
);

  localparam int TW = (CRC_TIMEOUT > 1) ? $clog2(CRC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(CRC_TIMEOUT - 1);

  // Report bit order matches ALERT[6:4]: {TxSuccess, TxDiscarded, TxFailed}
  localparam logic [2:0] RPT_SUCCESS  = 3'b100;
  localparam logic [2:0] RPT_DISCARD  = 3'b010;
  localparam logic [2:0] RPT_FAIL     = 3'b001;
  localparam logic [2:0] RPT_RESET_OK = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    WAIT_CRC,
    REPORT
  } state_t;

  state_t        state, nextState;
  logic [2:0]    txType, nextTxType;
  logic [1:0]    retryCnt, nextRetryCnt;
  logic [1:0]    attempt, nextAttempt;
  logic [TW-1:0] timer, nextTimer;
  logic [2:0]    reportBits, nextReportBits;
  logic [2:0]    flags;
  logic          isSopType;
  logic          isResetType;
  logic          reqReserved;
  logic          rxDiscard;

  assign isSopType   = (txType < 3'd3);
  assign isResetType = (txType > 3'd4);
  assign reqReserved = (iTRANSMIT[2:0] == 3'd3) || (iTRANSMIT[2:0] == 3'd4);
  assign rxDiscard   = iRxMessage && isSopType;

  always_comb begin
    nextState      = state;
    nextTxType     = txType;
    nextRetryCnt   = retryCnt;
    nextAttempt    = attempt;
    nextTimer      = timer;
    nextReportBits = reportBits;
    case (state)
      IDLE: begin
        if (iTxReq) begin
          nextTxType   = iTRANSMIT[2:0];
          nextRetryCnt = iTRANSMIT[5:4];
          nextAttempt  = 2'd0;
          if (reqReserved) begin
            nextState      = REPORT;
            nextReportBits = RPT_FAIL;
          end else begin
            nextState = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        if (rxDiscard) begin
          nextState      = REPORT;
          nextReportBits = RPT_DISCARD;
        end else begin
          nextState = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (rxDiscard) begin
          nextState      = REPORT;
          nextReportBits = RPT_DISCARD;
        end else if (iPHY_TxDone) begin
          if (isResetType) begin
            nextState      = REPORT;
            nextReportBits = RPT_RESET_OK;
          end else begin
            nextState = WAIT_CRC;
            nextTimer = TIMER_LOAD;
          end
        end
      end
      WAIT_CRC: begin
        // GoodCRC outranks both a concurrent receive and the final timer cycle
        if (iGoodCRC) begin
          nextState      = REPORT;
          nextReportBits = RPT_SUCCESS;
        end else if (rxDiscard) begin
          nextState      = REPORT;
          nextReportBits = RPT_DISCARD;
        end else if (timer == '0) begin
          if (attempt == retryCnt) begin
            nextState      = REPORT;
            nextReportBits = RPT_FAIL;
          end else begin
            nextState   = LAUNCH;
            nextAttempt = attempt + 2'd1;
          end
        end else begin
          nextTimer = timer - TW'(1);
        end
      end
      REPORT: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= IDLE;
      txType       <= 3'd0;
      retryCnt     <= 2'd0;
      attempt      <= 2'd0;
      timer        <= '0;
      reportBits   <= 3'd0;
      flags        <= 3'd0;
      oPHY_TxStart <= 1'b0;
      oBusy        <= 1'b0;
      oTRANSMIT    <= 8'd0;
    end else begin
      state        <= nextState;
      txType       <= nextTxType;
      retryCnt     <= nextRetryCnt;
      attempt      <= nextAttempt;
      timer        <= nextTimer;
      reportBits   <= nextReportBits;
      oPHY_TxStart <= (state == LAUNCH) && (nextState == WAIT_DONE);
      oBusy        <= (nextState != IDLE);
      oTRANSMIT    <= (state == REPORT) ? 8'd0 : iTRANSMIT;
      // Host W1C reaches us through iAlert; only honoured while idle
      if (state == REPORT) begin
        flags <= flags | reportBits;
      end else if (state == IDLE) begin
        flags <= flags & iAlert[6:4];
      end
    end
  end

  assign oPHY_TxType = txType;

  always_comb begin
    oAlert      = iAlert;
    oAlert[6:4] = iAlert[6:4] | flags;
  end

endmodule

// File: tb/tb_tx_retry_control.sv
// tb/tb_tx_retry_control.sv - directed self-checking bench for tx_retry_control
// A small register-bank model feeds oAlert back into iAlert with host set/clear masks.
`timescale 1ns/1ps
module tb_tx_retry_control;

  localparam int CRC_TIMEOUT = 16;
  localparam int ALERT_W     = 16;
  localparam int DONE_DELAY  = 2;

  logic               CLK = 1'b0;
  logic               reset;
  logic [7:0]         iTRANSMIT;
  logic               iTxReq;
  logic [ALERT_W-1:0] iAlert;
  logic [ALERT_W-1:0] oAlert;
  logic               iRxMessage;
  logic               oPHY_TxStart;
  logic [2:0]         oPHY_TxType;
  logic               iPHY_TxDone;
  logic               iGoodCRC;
  logic               oBusy;
  logic [7:0]         oTRANSMIT;

  logic [ALERT_W-1:0] bankAlert;
  logic [ALERT_W-1:0] hostSet;
  logic [ALERT_W-1:0] clearMask;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int startCount = 0;

  tx_retry_control #(
    .CRC_TIMEOUT(CRC_TIMEOUT),
    .ALERT_W    (ALERT_W)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .iTRANSMIT   (iTRANSMIT),
    .iTxReq      (iTxReq),
    .iAlert      (iAlert),
    .oAlert      (oAlert),
    .iRxMessage  (iRxMessage),
    .oPHY_TxStart(oPHY_TxStart),
    .oPHY_TxType (oPHY_TxType),
    .iPHY_TxDone (iPHY_TxDone),
    .iGoodCRC    (iGoodCRC),
    .oBusy       (oBusy),
    .oTRANSMIT   (oTRANSMIT)
  );

  always #5 CLK = ~CLK;

  assign iAlert = bankAlert;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (reset) bankAlert <= '0;
    else       bankAlert <= (oAlert | hostSet) & ~clearMask;
  end

  always @(negedge CLK) begin
    if (oPHY_TxStart === 1'b1) startCount <= startCount + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic request(input logic [2:0] typ, input logic [1:0] retry);
    iTRANSMIT = {2'b00, retry, 1'b0, typ};
    iTxReq    = 1'b1;
    tick();
    iTxReq    = 1'b0;
  endtask

  task automatic pulseTxDone();
    iPHY_TxDone = 1'b1;
    tick();
    iPHY_TxDone = 1'b0;
  endtask

  task automatic clearAlerts();
    clearMask = '1;
    tick();
    tick();
    clearMask = '0;
    tick();
  endtask

  task automatic waitStart(output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < 60; i++) begin
      if (oPHY_TxStart === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({oBusy, oPHY_TxStart, oPHY_TxType, oTRANSMIT, oAlert} !== '0) begin
      failures++;
      $display("FAIL reset_values: busy=%b start=%b type=%0d transmit=%h alert=%h, all required 0",
               oBusy, oPHY_TxStart, oPHY_TxType, oTRANSMIT, oAlert);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    hostSet = 16'h8003;
    tick();
    hostSet = '0;
    checks++;
    if (oAlert !== 16'h8003) begin
      failures++;
      $display("FAIL alert_passthrough: got %h expected 8003", oAlert);
    end
    clearAlerts();
  endtask

  task automatic test_sop_success();
    int n0;
    n0 = startCount;
    request(3'd0, 2'd3);
    checks++;
    if (oBusy !== 1'b1 || oPHY_TxStart !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_req: busy=%b start=%b expected busy=1 start=0", oBusy, oPHY_TxStart);
    end
    checks++;
    if (oTRANSMIT !== 8'h30) begin
      failures++;
      $display("FAIL transmit_passthrough: got %h expected 30", oTRANSMIT);
    end
    tick();
    checks++;
    if (oPHY_TxStart !== 1'b1) begin
      failures++;
      $display("FAIL start_latency: start=%b expected 1 two cycles after request", oPHY_TxStart);
    end
    tick();
    checks++;
    if (oPHY_TxStart !== 1'b0) begin
      failures++;
      $display("FAIL start_width: start=%b expected 0 on second cycle", oPHY_TxStart);
    end
    tick();
    pulseTxDone();
    tick();
    iGoodCRC = 1'b1;
    tick();
    iGoodCRC = 1'b0;
    checks++;
    if (oAlert[6] !== 1'b0 || oBusy !== 1'b1) begin
      failures++;
      $display("FAIL success_report_cycle: alert6=%b busy=%b expected 0 and 1", oAlert[6], oBusy);
    end
    tick();
    checks++;
    if (oAlert !== 16'h0040 || oBusy !== 1'b0 || oTRANSMIT !== 8'h00) begin
      failures++;
      $display("FAIL sop_success: alert=%h busy=%b transmit=%h expected 0040 0 00", oAlert, oBusy, oTRANSMIT);
    end
    repeat (25) tick();
    checks++;
    if (startCount - n0 !== 1) begin
      failures++;
      $display("FAIL sop_success_launches: got %0d expected 1", startCount - n0);
    end
    clearAlerts();
  endtask

  task automatic test_retry_exhaust();
    int n0;
    int s;
    int prev;
    bit ok;
    n0   = startCount;
    prev = -1;
    request(3'd1, 2'd2);
    for (int a = 0; a < 3; a++) begin
      waitStart(ok, s);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL retry_launch%0d: no start within bound", a);
      end
      if (a == 0) begin
        checks++;
        if (oPHY_TxType !== 3'd1) begin
          failures++;
          $display("FAIL retry_type: got %0d expected 1", oPHY_TxType);
        end
      end else begin
        checks++;
        if (s - prev !== DONE_DELAY + CRC_TIMEOUT + 2) begin
          failures++;
          $display("FAIL retry_spacing%0d: got %0d expected %0d", a, s - prev, DONE_DELAY + CRC_TIMEOUT + 2);
        end
      end
      prev = s;
      repeat (DONE_DELAY) tick();
      pulseTxDone();
    end
    repeat (CRC_TIMEOUT - 1) tick();
    checks++;
    if (oBusy !== 1'b1 || oAlert[4] !== 1'b0) begin
      failures++;
      $display("FAIL retry_last_wait: busy=%b alert4=%b expected 1 and 0", oBusy, oAlert[4]);
    end
    tick();
    tick();
    checks++;
    if (oAlert !== 16'h0010 || oBusy !== 1'b0) begin
      failures++;
      $display("FAIL retry_failed: alert=%h busy=%b expected 0010 0", oAlert, oBusy);
    end
    repeat (25) tick();
    checks++;
    if (startCount - n0 !== 3) begin
      failures++;
      $display("FAIL retry_launches: got %0d expected 3", startCount - n0);
    end
    clearAlerts();
  endtask

  task automatic test_hard_reset();
    int n0;
    n0 = startCount;
    request(3'd5, 2'd3);
    tick();
    checks++;
    if (oPHY_TxStart !== 1'b1 || oPHY_TxType !== 3'd5) begin
      failures++;
      $display("FAIL hard_reset_start: start=%b type=%0d expected 1 5", oPHY_TxStart, oPHY_TxType);
    end
    tick();
    tick();
    pulseTxDone();
    checks++;
    if (oAlert[6:5] !== 2'b00 || oBusy !== 1'b1) begin
      failures++;
      $display("FAIL hard_reset_report_cycle: alert65=%b busy=%b expected 00 1", oAlert[6:5], oBusy);
    end
    tick();
    checks++;
    if (oAlert !== 16'h0060 || oBusy !== 1'b0) begin
      failures++;
      $display("FAIL hard_reset_alert: alert=%h busy=%b expected 0060 0", oAlert, oBusy);
    end
    repeat (25) tick();
    checks++;
    if (startCount - n0 !== 1) begin
      failures++;
      $display("FAIL hard_reset_launches: got %0d expected 1", startCount - n0);
    end
    clearAlerts();
  endtask

  task automatic test_discard();
    int n0;
    n0 = startCount;
    request(3'd0, 2'd3);
    tick();
    tick();
    tick();
    pulseTxDone();
    iTRANSMIT = 8'h05;
    iTxReq    = 1'b1;
    tick();
    iTxReq    = 1'b0;
    iTRANSMIT = 8'h30;
    checks++;
    if (oPHY_TxType !== 3'd0 || oBusy !== 1'b1) begin
      failures++;
      $display("FAIL busy_req_ignored: type=%0d busy=%b expected 0 1", oPHY_TxType, oBusy);
    end
    iRxMessage = 1'b1;
    tick();
    iRxMessage = 1'b0;
    tick();
    checks++;
    if (oAlert !== 16'h0020 || oBusy !== 1'b0) begin
      failures++;
      $display("FAIL discard_alert: alert=%h busy=%b expected 0020 0", oAlert, oBusy);
    end
    repeat (25) tick();
    checks++;
    if (startCount - n0 !== 1) begin
      failures++;
      $display("FAIL discard_launches: got %0d expected 1", startCount - n0);
    end
    clearAlerts();
  endtask

  task automatic test_crc_at_expiry();
    int n0;
    n0 = startCount;
    request(3'd0, 2'd1);
    tick();
    tick();
    tick();
    pulseTxDone();
    repeat (CRC_TIMEOUT - 1) tick();
    iGoodCRC = 1'b1;
    tick();
    iGoodCRC = 1'b0;
    tick();
    checks++;
    if (oAlert !== 16'h0040 || oBusy !== 1'b0) begin
      failures++;
      $display("FAIL crc_at_expiry: alert=%h busy=%b expected 0040 0", oAlert, oBusy);
    end
    repeat (25) tick();
    checks++;
    if (startCount - n0 !== 1) begin
      failures++;
      $display("FAIL crc_at_expiry_launches: got %0d expected 1", startCount - n0);
    end
    clearAlerts();
  endtask

  task automatic test_reset_abort();
    int n0;
    n0 = startCount;
    request(3'd0, 2'd3);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({oBusy, oPHY_TxStart, oPHY_TxType, oTRANSMIT, oAlert} !== '0) begin
      failures++;
      $display("FAIL reset_abort_outputs: busy=%b start=%b type=%0d transmit=%h alert=%h, all required 0",
               oBusy, oPHY_TxStart, oPHY_TxType, oTRANSMIT, oAlert);
    end
    reset = 1'b0;
    pulseTxDone();
    iGoodCRC = 1'b1;
    tick();
    iGoodCRC = 1'b0;
    repeat (25) tick();
    checks++;
    if (startCount - n0 !== 1 || oAlert !== 16'h0000 || oBusy !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort_after: launches=%0d alert=%h busy=%b expected 1 0000 0",
               startCount - n0, oAlert, oBusy);
    end
  endtask

  task automatic test_reserved_type();
    int n0;
    n0 = startCount;
    request(3'd3, 2'd1);
    checks++;
    if (oBusy !== 1'b1) begin
      failures++;
      $display("FAIL reserved_busy: got %b expected 1", oBusy);
    end
    tick();
    checks++;
    if (oAlert !== 16'h0010 || oBusy !== 1'b0 || oTRANSMIT !== 8'h00) begin
      failures++;
      $display("FAIL reserved_failed: alert=%h busy=%b transmit=%h expected 0010 0 00", oAlert, oBusy, oTRANSMIT);
    end
    repeat (4) tick();
    checks++;
    if (oAlert[4] !== 1'b1) begin
      failures++;
      $display("FAIL reserved_held: alert4=%b expected 1", oAlert[4]);
    end
    clearMask = 16'h0010;
    repeat (3) tick();
    clearMask = '0;
    tick();
    checks++;
    if (oAlert !== 16'h0000) begin
      failures++;
      $display("FAIL flag_clear: alert=%h expected 0000", oAlert);
    end
    checks++;
    if (startCount - n0 !== 0) begin
      failures++;
      $display("FAIL reserved_launches: got %0d expected 0", startCount - n0);
    end
  endtask

  initial begin
    reset       = 1'b1;
    iTRANSMIT   = 8'h00;
    iTxReq      = 1'b0;
    iRxMessage  = 1'b0;
    iPHY_TxDone = 1'b0;
    iGoodCRC    = 1'b0;
    hostSet     = '0;
    clearMask   = '0;
    test_reset();
    test_passthrough();
    test_sop_success();
    test_retry_exhaust();
    test_hard_reset();
    test_discard();
    test_crc_at_expiry();
    test_reset_abort();
    test_reserved_type();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
